fetch_redirect: RTL and testbench

Next-PC generator and pipeline-flush controller for the 16-bit pipelined core. It receives the jump predictor's outputs: the ID-stage prediction, and the MEM-stage miss and address-miss flags with their evacuated fall-through PC. From these it selects the next fetch address, issues per-stage flush strobes, and tracks recovery after a misprediction. It sits in front of the IF-stage PC register and also keeps saturating prediction statistics for the debug port.

---
 rtl/fetch_pkg.sv | 8 +
 rtl/fetch_redirect_if.sv | 37 +++
 rtl/sat_counter.sv | 19 +
 rtl/fetch_redirect.sv | 103 ++++++++++
 tb/tb_fetch_redirect.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch redirect block.
// Recovery depth matches the number of pipeline stages killed by a MEM correction.
package fetch_pkg;
    typedef enum logic [1:0] {RUN, RECOVER, HALTED} fetch_state_t;

    localparam int RCNT_W = 2;
    localparam logic [RCNT_W-1:0] FLUSH_DEPTH = 2'd3;
endpackage

// File: rtl/fetch_redirect_if.sv
// Bundle between the pipeline/predictor side (master) and the next-PC generator (slave).
// Carries predictor results, hazard controls, fetch address, flush strobes and statistics.
interface fetch_redirect_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
);
    logic             stall;
    logic             halt;
    logic             jump_pred;
    logic [WIDTH-1:0] jump_pred_adr;
    logic             jump_pred_miss;
    logic             jump_pred_adr_miss;
    logic [WIDTH-1:0] pcinc_evac;
    logic [WIDTH-1:0] ALUres_mem;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pcinc;
    logic             flush_if;
    logic             flush_id;
    logic             flush_ex;
    logic             recovering;
    logic [CNT_W-1:0] pred_cnt;
    logic [CNT_W-1:0] miss_cnt;

    modport master (
        output stall, halt, jump_pred, jump_pred_adr, jump_pred_miss,
               jump_pred_adr_miss, pcinc_evac, ALUres_mem,
        input  pc, pcinc, flush_if, flush_id, flush_ex, recovering,
               pred_cnt, miss_cnt
    );

    modport slave (
        input  stall, halt, jump_pred, jump_pred_adr, jump_pred_miss,
               jump_pred_adr_miss, pcinc_evac, ALUres_mem,
        output pc, pcinc, flush_if, flush_id, flush_ex, recovering,
               pred_cnt, miss_cnt
    );
endinterface

// File: rtl/sat_counter.sv
// Saturating event counter; sticks at all-ones instead of wrapping.
// Latency: value updates one cycle after inc. Backpressure: none, inc is sampled every cycle.
// Synchronous clear has priority over increment.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] value
);
    always_ff @(posedge clk) begin
        if (clr) begin
            value <= '0;
        end else if (inc && (value != {CNT_W{1'b1}})) begin
            value <= value + 1'b1;
        end
    end
endmodule

// File: rtl/fetch_redirect.sv
// Next-PC select and pipeline flush control: MEM correction > ID prediction > stall > pc+1.
// Latency: redirect target lands on pc one cycle after the request; flushes are same-cycle combinational.
// Backpressure: stall holds pc unless a prediction or correction redirects; halt freezes until reset.
module fetch_redirect
    import fetch_pkg::*;
#(
    parameter int               WIDTH    = 16,
    parameter logic [WIDTH-1:0] RESET_PC = 16'h0000,
    parameter int               CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    fetch_redirect_if.slave  bus
);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    fetch_state_t      state_q, state_d;
    logic [RCNT_W-1:0] rcnt_q, rcnt_d;
    logic [WIDTH-1:0]  pc_q, pc_d, pcinc_q;
    logic              correction;
    logic              flush_if_c, flush_id_c, flush_ex_c;
    logic              pred_inc, miss_inc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            rcnt_q  <= '0;
            pc_q    <= RESET_PC;
            pcinc_q <= RESET_PC + ONE;
        end else begin
            state_q <= state_d;
            rcnt_q  <= rcnt_d;
            pc_q    <= pc_d;
            pcinc_q <= pc_d + ONE;
        end
    end

    always_comb begin
        state_d    = state_q;
        rcnt_d     = rcnt_q;
        pc_d       = pc_q;
        flush_if_c = 1'b0;
        flush_id_c = 1'b0;
        flush_ex_c = 1'b0;
        pred_inc   = 1'b0;
        miss_inc   = 1'b0;
        correction = (bus.jump_pred_miss || bus.jump_pred_adr_miss) && (state_q != HALTED);

        if (state_q == RECOVER) begin
            if (rcnt_q == 2'd1) begin
                state_d = RUN;
                rcnt_d  = '0;
            end else begin
                rcnt_d = rcnt_q - 1'b1;
            end
        end

        if (state_q != HALTED) begin
            if (correction) begin
                // Address miss carries the real target, so it beats a plain not-taken miss.
                pc_d       = bus.jump_pred_adr_miss ? bus.ALUres_mem : bus.pcinc_evac;
                flush_if_c = 1'b1;
                flush_id_c = 1'b1;
                flush_ex_c = 1'b1;
                miss_inc   = 1'b1;
                state_d    = RECOVER;
                rcnt_d     = FLUSH_DEPTH;
            end else if (bus.jump_pred && (state_q == RUN)) begin
                // ID only holds bubbles during RECOVER, so predictions there are dropped.
                pc_d       = bus.jump_pred_adr;
                flush_if_c = 1'b1;
                pred_inc   = 1'b1;
            end else if (!bus.stall) begin
                pc_d = pc_q + ONE;
            end
        end

        if (bus.halt) begin
            state_d = HALTED;
        end
    end

    assign bus.pc         = pc_q;
    assign bus.pcinc      = pcinc_q;
    assign bus.flush_if   = flush_if_c && !reset;
    assign bus.flush_id   = flush_id_c && !reset;
    assign bus.flush_ex   = flush_ex_c && !reset;
    assign bus.recovering = (state_q == RECOVER) && !reset;

    sat_counter #(.CNT_W(CNT_W)) u_pred_cnt (
        .clk   (clk),
        .inc   (pred_inc && !reset),
        .clr   (reset),
        .value (bus.pred_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_miss_cnt (
        .clk   (clk),
        .inc   (miss_inc && !reset),
        .clr   (reset),
        .value (bus.miss_cnt)
    );
endmodule

// File: tb/tb_fetch_redirect.sv
// Directed bench for fetch_redirect: each task drives one scenario and checks hand-computed values.
module tb_fetch_redirect;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    fetch_redirect_if #(.WIDTH(16), .CNT_W(16)) bus ();

    fetch_redirect #(.WIDTH(16), .RESET_PC(16'h0000), .CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus.stall = 0; bus.halt = 0; bus.jump_pred = 0; bus.jump_pred_adr = '0;
        bus.jump_pred_miss = 0; bus.jump_pred_adr_miss = 0;
        bus.pcinc_evac = '0; bus.ALUres_mem = '0;
    endtask

    task automatic test_reset;
        idle_inputs();
        reset = 1;
        bus.jump_pred_miss = 1;
        bus.pcinc_evac = 16'h0033;
        #1;
        checks++; if ({bus.flush_if, bus.flush_id, bus.flush_ex} !== 3'b000) begin errors++; $display("FAIL reset_flush got %b want 000", {bus.flush_if, bus.flush_id, bus.flush_ex}); end
        tick(); tick();
        checks++; if ({bus.flush_if, bus.flush_id, bus.flush_ex} !== 3'b000) begin errors++; $display("FAIL reset_flush2 got %b want 000", {bus.flush_if, bus.flush_id, bus.flush_ex}); end
        bus.jump_pred_miss = 0;
        reset = 0;
        #1;
        checks++; if (bus.pc !== 16'h0000) begin errors++; $display("FAIL reset_pc got %h want 0000", bus.pc); end
        checks++; if (bus.pcinc !== 16'h0001) begin errors++; $display("FAIL reset_pcinc got %h want 0001", bus.pcinc); end
        checks++; if (bus.recovering !== 1'b0) begin errors++; $display("FAIL reset_recovering got %b want 0", bus.recovering); end
        checks++; if (bus.pred_cnt !== 16'h0 || bus.miss_cnt !== 16'h0) begin errors++; $display("FAIL reset_cnt got %h/%h want 0/0", bus.pred_cnt, bus.miss_cnt); end
        for (int i = 1; i <= 4; i++) begin
            tick();
            checks++; if (bus.pc !== 16'(i)) begin errors++; $display("FAIL idle_pc got %h want %h", bus.pc, 16'(i)); end
            checks++; if ({bus.flush_if, bus.flush_id, bus.flush_ex} !== 3'b000) begin errors++; $display("FAIL idle_flush got %b want 000", {bus.flush_if, bus.flush_id, bus.flush_ex}); end
        end
        tick();
    endtask

    task automatic test_predict;
        checks++; if (bus.pc !== 16'h0005) begin errors++; $display("FAIL pred_start_pc got %h want 0005", bus.pc); end
        bus.jump_pred = 1; bus.jump_pred_adr = 16'h0040;
        #1;
        checks++; if ({bus.flush_if, bus.flush_id, bus.flush_ex} !== 3'b100) begin errors++; $display("FAIL pred_flush got %b want 100", {bus.flush_if, bus.flush_id, bus.flush_ex}); end
        tick();
        bus.jump_pred = 0;
        checks++; if (bus.pc !== 16'h0040) begin errors++; $display("FAIL pred_pc got %h want 0040", bus.pc); end
        checks++; if (bus.pcinc !== 16'h0041) begin errors++; $display("FAIL pred_pcinc got %h want 0041", bus.pcinc); end
        checks++; if (bus.pred_cnt !== 16'd1) begin errors++; $display("FAIL pred_cnt got %0d want 1", bus.pred_cnt); end
    endtask

    task automatic test_mispredict;
        bus.jump_pred_miss = 1; bus.pcinc_evac = 16'h0006;
        #1;
        checks++; if ({bus.flush_if, bus.flush_id, bus.flush_ex} !== 3'b111) begin errors++; $display("FAIL miss_flush got %b want 111", {bus.flush_if, bus.flush_id, bus.flush_ex}); end
        tick();
        bus.jump_pred_miss = 0;
        checks++; if (bus.pc !== 16'h0006) begin errors++; $display("FAIL miss_pc got %h want 0006", bus.pc); end
        checks++; if (bus.miss_cnt !== 16'd1) begin errors++; $display("FAIL miss_cnt got %0d want 1", bus.miss_cnt); end
        bus.jump_pred = 1; bus.jump_pred_adr = 16'h0077;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (bus.recovering !== 1'b1) begin errors++; $display("FAIL miss_recovering cycle %0d got %b want 1", i, bus.recovering); end
            checks++; if (bus.flush_if !== 1'b0) begin errors++; $display("FAIL miss_ignored_flush cycle %0d got %b want 0", i, bus.flush_if); end
            tick();
            checks++; if (bus.pc !== 16'(7 + i)) begin errors++; $display("FAIL miss_recover_pc got %h want %h", bus.pc, 16'(7 + i)); end
        end
        bus.jump_pred = 0;
        checks++; if (bus.recovering !== 1'b0) begin errors++; $display("FAIL miss_recover_end got %b want 0", bus.recovering); end
        checks++; if (bus.pred_cnt !== 16'd1) begin errors++; $display("FAIL miss_pred_cnt got %0d want 1", bus.pred_cnt); end
    endtask

    task automatic test_adr_miss_reload;
        bus.jump_pred_miss = 1; bus.jump_pred_adr_miss = 1;
        bus.ALUres_mem = 16'h0100; bus.pcinc_evac = 16'h0055;
        tick();
        bus.jump_pred_miss = 0; bus.jump_pred_adr_miss = 0;
        checks++; if (bus.pc !== 16'h0100) begin errors++; $display("FAIL both_pc got %h want 0100", bus.pc); end
        checks++; if (bus.miss_cnt !== 16'd2) begin errors++; $display("FAIL both_miss_cnt got %0d want 2", bus.miss_cnt); end
        tick();
        checks++; if (bus.recovering !== 1'b1) begin errors++; $display("FAIL reload_pre got %b want 1", bus.recovering); end
        bus.jump_pred_adr_miss = 1; bus.ALUres_mem = 16'h0200;
        tick();
        bus.jump_pred_adr_miss = 0;
        checks++; if (bus.pc !== 16'h0200) begin errors++; $display("FAIL reload_pc got %h want 0200", bus.pc); end
        checks++; if (bus.miss_cnt !== 16'd3) begin errors++; $display("FAIL reload_miss_cnt got %0d want 3", bus.miss_cnt); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (bus.recovering !== 1'b1) begin errors++; $display("FAIL reload_recovering cycle %0d got %b want 1", i, bus.recovering); end
            tick();
        end
        checks++; if (bus.recovering !== 1'b0) begin errors++; $display("FAIL reload_end got %b want 0", bus.recovering); end
        checks++; if (bus.pc !== 16'h0203) begin errors++; $display("FAIL reload_end_pc got %h want 0203", bus.pc); end
    endtask

    task automatic test_stall;
        bus.jump_pred = 1; bus.jump_pred_adr = 16'h0010;
        tick();
        bus.jump_pred = 0; bus.stall = 1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (bus.pc !== 16'h0010) begin errors++; $display("FAIL stall_pc cycle %0d got %h want 0010", i, bus.pc); end
        end
        bus.jump_pred_adr_miss = 1; bus.ALUres_mem = 16'h0030;
        tick();
        bus.jump_pred_adr_miss = 0; bus.stall = 0;
        checks++; if (bus.pc !== 16'h0030) begin errors++; $display("FAIL stall_corr_pc got %h want 0030", bus.pc); end
        checks++; if (bus.miss_cnt !== 16'd4 || bus.pred_cnt !== 16'd2) begin errors++; $display("FAIL stall_cnts got %0d/%0d want 2/4", bus.pred_cnt, bus.miss_cnt); end
        repeat (3) tick();
    endtask

    task automatic test_wrap;
        bus.jump_pred = 1; bus.jump_pred_adr = 16'hFFFF;
        tick();
        bus.jump_pred = 0;
        checks++; if (bus.pc !== 16'hFFFF) begin errors++; $display("FAIL wrap_pc got %h want ffff", bus.pc); end
        checks++; if (bus.pcinc !== 16'h0000) begin errors++; $display("FAIL wrap_pcinc got %h want 0000", bus.pcinc); end
        tick();
        checks++; if (bus.pc !== 16'h0000) begin errors++; $display("FAIL wrap_next_pc got %h want 0000", bus.pc); end
        checks++; if (bus.pred_cnt !== 16'd3) begin errors++; $display("FAIL wrap_pred_cnt got %0d want 3", bus.pred_cnt); end
    endtask

    task automatic test_halt;
        bus.halt = 1; bus.jump_pred_adr_miss = 1; bus.ALUres_mem = 16'h0ABC;
        tick();
        bus.halt = 0; bus.jump_pred_adr_miss = 0;
        checks++; if (bus.pc !== 16'h0ABC) begin errors++; $display("FAIL halt_corr_pc got %h want 0abc", bus.pc); end
        bus.jump_pred_miss = 1; bus.pcinc_evac = 16'h0999; bus.jump_pred = 1; bus.jump_pred_adr = 16'h0555;
        #1;
        checks++; if ({bus.flush_if, bus.flush_id, bus.flush_ex} !== 3'b000) begin errors++; $display("FAIL halt_flush got %b want 000", {bus.flush_if, bus.flush_id, bus.flush_ex}); end
        checks++; if (bus.recovering !== 1'b0) begin errors++; $display("FAIL halt_recovering got %b want 0", bus.recovering); end
        repeat (3) tick();
        checks++; if (bus.pc !== 16'h0ABC) begin errors++; $display("FAIL halt_hold_pc got %h want 0abc", bus.pc); end
        checks++; if (bus.miss_cnt !== 16'd5 || bus.pred_cnt !== 16'd3) begin errors++; $display("FAIL halt_cnts got %0d/%0d want 3/5", bus.pred_cnt, bus.miss_cnt); end
        idle_inputs();
    endtask

    task automatic test_saturation;
        reset = 1;
        tick();
        reset = 0;
        checks++; if (bus.pc !== 16'h0000 || bus.pred_cnt !== 16'd0 || bus.miss_cnt !== 16'd0) begin errors++; $display("FAIL unhalt got pc %h cnt %0d/%0d want 0000 0/0", bus.pc, bus.pred_cnt, bus.miss_cnt); end
        tick();
        checks++; if (bus.pc !== 16'h0001) begin errors++; $display("FAIL unhalt_run_pc got %h want 0001", bus.pc); end
        bus.jump_pred = 1; bus.jump_pred_adr = 16'h0123;
        repeat (65535) @(posedge clk);
        #1;
        checks++; if (bus.pred_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_reach got %h want ffff", bus.pred_cnt); end
        repeat (3) tick();
        bus.jump_pred = 0;
        checks++; if (bus.pred_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hold got %h want ffff", bus.pred_cnt); end
        checks++; if (bus.pc !== 16'h0123) begin errors++; $display("FAIL sat_pc got %h want 0123", bus.pc); end
    endtask

    initial begin
        test_reset();
        test_predict();
        test_mispredict();
        test_adr_miss_reload();
        test_stall();
        test_wrap();
        test_halt();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
